alu_access_ctrl: RTL and testbench

Arbiter and sequencer that shares the single 32-bit accumulator ALU between two requesters. It grants the ALU to one requester at a time and issues that requester's opcode and operand on the ALU's instruction and B inputs. It returns the updated accumulator value and zero flag to the requester. A requester may lock the ALU across a multi-operation sequence, for example LOAD, ADD, SUB, bounded by a lock watchdog.

---
 rtl/alu_access_ctrl_pkg.sv | 30 +++
 rtl/alu_access_ctrl_rr_arbiter2.sv | 32 +++
 rtl/alu_access_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_alu_access_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_access_ctrl_pkg.sv
// Shared definitions for the accumulator ALU and its access controller:
// opcode map, idle instruction, datapath widths and sequencer states.
package alu_access_ctrl_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 8;

    // ALU opcode map; anything above ALU_OP_LOAD is not an ALU operation
    localparam logic [ALU_OP_W-1:0] ALU_OP_CLEAR = 8'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_INC   = 8'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DEC   = 8'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 8'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 8'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL2  = 8'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL4  = 8'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DIV16 = 8'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LOAD  = 8'd8;

    // Idle instruction: CLEAR is 0, so the bus must never rest at 0
    localparam logic [ALU_OP_W-1:0] ALU_NOP_CODE = 8'hFF;

    // Sequencer states of the access controller
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RESULT = 2'd2,
        ST_HOLD   = 2'd3
    } acc_state_t;

endpackage

// File: rtl/alu_access_ctrl_rr_arbiter2.sv
// Two-way round-robin grant. The priority bit only moves on an explicit
// update strobe, so a locked owner does not disturb fairness.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_pri,
    output logic [1:0] gnt,
    output logic       pri
);

    logic pri_q;

    // Priority pointer: requester that wins when both ask
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pri_q <= 1'b0;
        else if (upd)
            pri_q <= upd_pri;
    end

    // One-hot grant: a lone requester always wins, a tie goes to pri
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = pri_q ? 2'b10 : 2'b01;
    end

    assign pri = pri_q;

endmodule

// File: rtl/alu_access_ctrl.sv
// Shares one accumulator ALU between two requesters. Grants one command at
// a time, drives the ALU instruction/B bus for a single cycle, returns the
// accumulator and zero flag, and supports multi-op locks with a watchdog.
module alu_access_ctrl
    import alu_access_ctrl_pkg::*;
#(
    parameter int                DATA_W       = ALU_DATA_W,
    parameter int                OP_W         = ALU_OP_W,
    parameter logic [OP_W-1:0]   NOP_CODE     = OP_W'(ALU_NOP_CODE),
    parameter int                LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req0_last,
    input  logic              req1_last,
    output logic [1:0]        req_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_z,
    output logic              rsp_err,
    output logic              lock_timeout,
    output logic [OP_W-1:0]   alu_instruction,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_a,
    input  logic              alu_z
);

    localparam logic [7:0] TMR_LAST = 8'(LOCK_TIMEOUT - 1);

    acc_state_t        state_q, state_d;
    logic              owner_q;
    logic              last_q;
    logic              err_q;
    logic [7:0]        timer_q;
    logic [OP_W-1:0]   alu_instr_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_z_q;
    logic              rsp_err_q;

    logic [1:0]        arb_gnt;
    logic              arb_pri;
    logic              pri_upd;
    logic              accept;
    logic              acc_id;
    logic              timer_clr;
    logic              timer_inc;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_b;
    logic              sel_last;
    logic              sel_legal;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .upd     (pri_upd),
        .upd_pri (~owner_q),
        .gnt     (arb_gnt),
        .pri     (arb_pri)
    );

    // Command of whichever requester is being accepted this cycle
    always_comb begin
        sel_op    = acc_id ? req1_op   : req0_op;
        sel_b     = acc_id ? req1_b    : req0_b;
        sel_last  = acc_id ? req1_last : req0_last;
        sel_legal = (sel_op <= OP_W'(ALU_OP_LOAD));
    end

    // Next-state, accept strobes, lock watchdog and response pulse
    always_comb begin
        state_d      = state_q;
        req_ready    = 2'b00;
        accept       = 1'b0;
        acc_id       = owner_q;
        pri_upd      = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        lock_timeout = 1'b0;
        rsp_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    req_ready = arb_gnt;
                    accept    = 1'b1;
                    acc_id    = arb_gnt[1];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                rsp_valid = 1'b1;
                if (last_q) begin
                    pri_upd = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_clr = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // An owner command beats a watchdog expiry in the same cycle
                if (req_valid[owner_q]) begin
                    req_ready[owner_q] = 1'b1;
                    accept             = 1'b1;
                    state_d            = ST_ISSUE;
                end else if (timer_q == TMR_LAST) begin
                    lock_timeout = 1'b1;
                    pri_upd      = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Never strobe ready while the block is held in reset
        if (!reset)
            req_ready = 2'b00;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Capture owner, lock intent and legality of the accepted command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            owner_q <= acc_id;
            last_q  <= sel_last;
            err_q   <= ~sel_legal;
        end
    end

    // ALU bus: the opcode appears only in the cycle after a legal accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_instr_q <= NOP_CODE;
            alu_b_q     <= '0;
        end else if (accept && sel_legal) begin
            alu_instr_q <= sel_op;
            alu_b_q     <= sel_b;
        end else begin
            alu_instr_q <= NOP_CODE;
            alu_b_q     <= '0;
        end
    end

    // Lock watchdog: counts idle HOLD cycles since the last result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timer_q <= 8'd0;
        else if (timer_clr)
            timer_q <= 8'd0;
        else if (timer_inc)
            timer_q <= timer_q + 8'd1;
    end

    // Response hold registers keep the last result visible between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == ST_RESULT) begin
            rsp_id_q   <= owner_q;
            rsp_data_q <= alu_a;
            rsp_z_q    <= alu_z;
            rsp_err_q  <= err_q;
        end
    end

    // The ALU result is only settled in RESULT, so pass it straight through
    // then and fall back to the held copy otherwise.
    assign rsp_id          = (state_q == ST_RESULT) ? owner_q : rsp_id_q;
    assign rsp_data        = (state_q == ST_RESULT) ? alu_a   : rsp_data_q;
    assign rsp_z           = (state_q == ST_RESULT) ? alu_z   : rsp_z_q;
    assign rsp_err         = (state_q == ST_RESULT) ? err_q   : rsp_err_q;
    assign alu_instruction = alu_instr_q;
    assign alu_b           = alu_b_q;

endmodule

// File: tb/tb_alu_access_ctrl.sv
// Bench for alu_access_ctrl: directed commands, a small accumulator ALU
// model, and a scoreboard queue drained by an independent response monitor.
module tb_alu_access_ctrl;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        z;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [7:0]  op0 = 8'd0, op1 = 8'd0;
    logic [31:0] b0 = 32'd0, b1 = 32'd0;
    logic        l0 = 1'b0, l1 = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        rsp_valid, rsp_id, rsp_z, rsp_err, lock_timeout;
    logic [31:0] rsp_data;
    logic [7:0]  alu_instruction;
    logic [31:0] alu_b;
    logic [31:0] acc = 32'd0;
    logic        alu_z;

    exp_t sb[$];
    exp_t mon_a, mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   bad_rdy = 0;
    bit   lock_win = 1'b0;

    assign req_valid = {v1, v0};
    assign alu_z     = (acc == 32'd0);

    always #5 clk = ~clk;

    alu_access_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req0_op         (op0),
        .req1_op         (op1),
        .req0_b          (b0),
        .req1_b          (b1),
        .req0_last       (l0),
        .req1_last       (l1),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rsp_z           (rsp_z),
        .rsp_err         (rsp_err),
        .lock_timeout    (lock_timeout),
        .alu_instruction (alu_instruction),
        .alu_b           (alu_b),
        .alu_a           (acc),
        .alu_z           (alu_z)
    );

    // Accumulator ALU: not reset by the controller
    always @(posedge clk) begin
        case (alu_instruction)
            8'd0: acc <= 32'd0;
            8'd1: acc <= acc + 32'd1;
            8'd2: acc <= acc - 32'd1;
            8'd3: acc <= acc + alu_b;
            8'd4: acc <= acc - alu_b;
            8'd5: acc <= acc << 1;
            8'd6: acc <= acc << 2;
            8'd7: acc <= acc >> 4;
            8'd8: acc <= alu_b;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [31:0] d, input logic z, input logic e);
        mk = {id, d, z, e};
    endfunction

    // Monitor: every response must match the oldest expectation
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            mon_a = {rsp_id, rsp_data, rsp_z, rsp_err};
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %h expected none at %0t", mon_a, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp", 64'(mon_a), 64'(mon_e));
            end
        end
    end

    // Count any req1 ready while req0 holds its lock
    always @(negedge clk) begin
        if (lock_win && req_ready[1])
            bad_rdy <= bad_rdy + 1;
    end

    // Present one command, wait for its accept, optionally push expectation
    task automatic send(input int id, input logic [7:0] op, input logic [31:0] b,
                        input logic last, input bit push, input exp_t e);
        bit ok = 1'b0;
        if (id == 0) begin op0 = op; b0 = b; l0 = last; v0 = 1'b1; end
        else         begin op1 = op; b1 = b; l1 = last; v1 = 1'b1; end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no ready expected ready for req%0d", id);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        // Reset state, with both requesters asking during reset
        v0 = 1'b1; v1 = 1'b1; op0 = 8'd1; op1 = 8'd1; l0 = 1'b1; l1 = 1'b1;
        #12;
        chk("rst_ready",  64'(req_ready), 64'(0));
        chk("rst_rvalid", 64'(rsp_valid), 64'(0));
        chk("rst_rid",    64'(rsp_id), 64'(0));
        chk("rst_rdata",  64'(rsp_data), 64'(0));
        chk("rst_rz",     64'(rsp_z), 64'(0));
        chk("rst_rerr",   64'(rsp_err), 64'(0));
        chk("rst_lto",    64'(lock_timeout), 64'(0));
        chk("rst_instr",  64'(alu_instruction), 64'hFF);
        chk("rst_b",      64'(alu_b), 64'(0));
        v0 = 1'b0; v1 = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        // Single op: LOAD 5 and its cycle timing
        send(0, 8'd8, 32'd5, 1'b1, 1'b1, mk(1'b0, 32'd5, 1'b0, 1'b0));
        @(negedge clk);
        chk("t1_instr_n1", 64'(alu_instruction), 64'd8);
        chk("t1_b_n1",     64'(alu_b), 64'd5);
        @(negedge clk);
        chk("t1_rvalid_n2", 64'(rsp_valid), 64'd1);
        chk("t1_instr_n2",  64'(alu_instruction), 64'hFF);

        // Locked sequence with req1 stalled behind it
        lock_win = 1'b1;
        fork
            begin
                send(0, 8'd8, 32'd10, 1'b0, 1'b1, mk(1'b0, 32'd10, 1'b0, 1'b0));
                send(0, 8'd4, 32'd10, 1'b0, 1'b1, mk(1'b0, 32'd0, 1'b1, 1'b0));
                send(0, 8'd1, 32'd0, 1'b1, 1'b1, mk(1'b0, 32'd1, 1'b0, 1'b0));
                lock_win = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                send(1, 8'd1, 32'd0, 1'b1, 1'b1, mk(1'b1, 32'd2, 1'b0, 1'b0));
            end
        join
        chk("lock_req1_ready", 64'(bad_rdy), 64'd0);

        // Contention: grants alternate 0,1,0,1
        sb.push_back(mk(1'b0, 32'd3,   1'b0, 1'b0));
        sb.push_back(mk(1'b1, 32'd103, 1'b0, 1'b0));
        sb.push_back(mk(1'b0, 32'd104, 1'b0, 1'b0));
        sb.push_back(mk(1'b1, 32'd204, 1'b0, 1'b0));
        fork
            begin
                send(0, 8'd1, 32'd0, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
                send(0, 8'd1, 32'd0, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
            end
            begin
                send(1, 8'd3, 32'd100, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
                send(1, 8'd3, 32'd100, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
            end
        join

        // Lock watchdog: LOAD 3 held, then abandoned
        send(0, 8'd8, 32'd3, 1'b0, 1'b1, mk(1'b0, 32'd3, 1'b0, 1'b0));
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (k = 1; k < 100; k++) begin
            @(negedge clk);
            if (lock_timeout) break;
        end
        chk("wd_cycles", 64'(k), 64'd16);
        send(1, 8'd1, 32'd0, 1'b1, 1'b1, mk(1'b1, 32'd4, 1'b0, 1'b0));

        // Illegal opcode: nothing issued, error flagged with current acc
        send(1, 8'd9, 32'd77, 1'b1, 1'b1, mk(1'b1, 32'd4, 1'b0, 1'b1));
        @(negedge clk);
        chk("ill_instr", 64'(alu_instruction), 64'hFF);
        @(negedge clk);

        // Reset while the INC is in ISSUE: dropped, outputs forced at once
        op1 = 8'd2; b1 = 32'd0; l1 = 1'b1; v1 = 1'b1;
        send(0, 8'd1, 32'd0, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
        reset = 1'b0;
        #1;
        chk("mid_instr",  64'(alu_instruction), 64'hFF);
        chk("mid_b",      64'(alu_b), 64'd0);
        chk("mid_ready",  64'(req_ready), 64'd0);
        chk("mid_rvalid", 64'(rsp_valid), 64'd0);
        chk("mid_rdata",  64'(rsp_data), 64'd0);
        chk("mid_rid",    64'(rsp_id), 64'd0);
        chk("mid_lto",    64'(lock_timeout), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        sb.push_back(mk(1'b0, 32'd7, 1'b0, 1'b0));
        sb.push_back(mk(1'b1, 32'd6, 1'b0, 1'b0));
        fork
            send(0, 8'd8, 32'd7, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
            send(1, 8'd2, 32'd0, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
        join

        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
